// File: rtl/mips_boot_loader.sv
// mips_boot_loader: framed byte-stream image loader that fills the core's Mem and holds/releases pipe_MIPS32.
// Defining LOADER_CHECKSUM_EN adds a trailing checksum word (CHK state) to the frame.
module mips_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              done,
    output logic              error
);
    localparam int NW = $clog2(MAX_WORDS + 1);
    localparam logic [32:0] MEM_WORDS = 33'(1) << ADDR_W;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] HDR_CNT  = 3'd1;
    localparam logic [2:0] HDR_ADDR = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] RUN      = 3'd5;
    localparam logic [2:0] ERR      = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK      = 3'd4;
    localparam logic [2:0] POST     = CHK;
    logic [31:0] sum;
`else
    localparam logic [2:0] POST     = RUN;
`endif

    logic [2:0]        state, nxt;
    logic [1:0]        bc;
    logic [23:0]       sh;
    logic [NW-1:0]     n, i;
    logic [ADDR_W-1:0] base;
    logic [31:0]       word;
    logic              take, word_done;

    assign take      = in_valid & in_ready;
    assign word_done = take & (bc == 2'd3);
    assign word      = {sh, in_data};

    // DATA stops taking bytes once all N words are in, so the last write finishes before leaving DATA
    always_comb begin
        in_ready = state == HDR_CNT || state == HDR_ADDR || (state == DATA && i != n);
`ifdef LOADER_CHECKSUM_EN
        in_ready = in_ready || state == CHK;
`endif
    end

    always_comb begin
        nxt = state;
        if (load_req)
            nxt = HDR_CNT;
        else
            case (state)
                HDR_CNT:  if (word_done) nxt = (word > 32'(MAX_WORDS)) ? ERR : HDR_ADDR;
                HDR_ADDR: if (word_done) nxt = ({1'b0, word} + 33'(n) > MEM_WORDS) ? ERR :
                                               (n == '0) ? POST : DATA;
                DATA:     if (mem_we && i == n) nxt = POST;
`ifdef LOADER_CHECKSUM_EN
                CHK:      if (word_done) nxt = (word == sum) ? RUN : ERR;
`endif
                default: ;
            endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bc        <= '0;
            sh        <= '0;
            n         <= '0;
            i         <= '0;
            base      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            cpu_start <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= nxt;
            cpu_hold  <= nxt != RUN;
            cpu_start <= nxt == RUN && state != RUN;
            done      <= nxt == RUN;
            error     <= nxt == ERR;
            mem_we    <= 1'b0;
            if (load_req) begin
                bc <= '0;
                i  <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum <= '0;
`endif
            end else begin
                if (take) begin
                    bc <= bc + 2'd1;
                    sh <= {sh[15:0], in_data};
                end
                if (word_done && state == HDR_CNT) n <= NW'(word);
                if (word_done && state == HDR_ADDR) base <= ADDR_W'(word);
                if (word_done && state == DATA) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= base + ADDR_W'(i);
                    mem_wdata <= word;
                    i         <= i + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum       <= sum + word;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_boot_loader.sv
// tb_mips_boot_loader: directed frames checked every cycle against a frame-level model and write scoreboard.
`timescale 1ns/1ps
module tb_mips_boot_loader;
    localparam int ADDR_W = 10;
    localparam int MAXW   = 1024;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk1 = 1'b0, rst_n = 1'b1, load_req = 1'b0, in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready, mem_we, cpu_hold, cpu_start, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    int errors = 0, checks = 0;
    logic [31:0]       pay[$], frame[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int                pay_n = 0, nbytes = 0, exp_writes = 0, writes = 0, starts = 0, byte_idx = 0;
    bit                exp_run = 1'b0, we_due = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0, first_data = '0;

    mips_boot_loader dut (
        .clk1(clk1), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .done(done), .error(error)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit hdr_valid(input logic [31:0] n, input logic [31:0] b);
        return n <= 32'(MAXW) && (64'(b) + 64'(n)) <= 64'(MAXW);
    endfunction

    function automatic logic [31:0] model_sum();
        logic [31:0] s = '0;
        foreach (pay[k]) s = s + pay[k];
        return s;
    endfunction

    // Builds the frame and everything the loader must do with it.
    task automatic plan(input logic [31:0] n, input logic [31:0] b, input logic [31:0] chk_xor);
        bit ok;
        ok = hdr_valid(n, b);
        frame.delete(); exp_addr.delete(); exp_data.delete();
        frame.push_back(n);
        frame.push_back(b);
        foreach (pay[k]) frame.push_back(pay[k]);
        if (CHK_EN) frame.push_back(model_sum() ^ chk_xor);
        nbytes = (n > 32'(MAXW)) ? 4 : !ok ? 8 : 4 * frame.size();
        if (ok)
            foreach (pay[k]) begin
                exp_addr.push_back(ADDR_W'(b + 32'(k)));
                exp_data.push_back(pay[k]);
            end
        pay_n      = ok ? int'(n) : 0;
        exp_writes = pay_n;
        exp_run    = ok && (!CHK_EN || chk_xor == 0);
        writes     = 0;
        starts     = 0;
    endtask

    always @(negedge clk1) begin
        if (!rst_n) begin
            we_due   = 1'b0;
            byte_idx = 0;
        end else begin
            check("mem_we timing", mem_we, we_due);
            if (mem_we) begin
                if (writes == 0) first_data = mem_wdata;
                writes++;
                last_addr = mem_addr;
                last_data = mem_wdata;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected write: addr %0d data %h, expected none", mem_addr, mem_wdata);
                end else begin
                    check("mem_addr", mem_addr, exp_addr.pop_front());
                    check("mem_wdata", mem_wdata, exp_data.pop_front());
                end
            end
            if (cpu_start) starts++;
            check("hold vs done", cpu_hold, !done);
            check("start implies done", cpu_start & ~done, 0);
            check("error keeps hold", error & ~cpu_hold, 0);
            we_due = 1'b0;
            if (load_req)
                byte_idx = 0;
            else if (in_valid && in_ready) begin
                we_due = byte_idx >= 8 && byte_idx < 8 + 4 * pay_n && byte_idx % 4 == 3;
                byte_idx++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk1); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(posedge clk1); #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte accept: in_ready=0 for 50 cycles, expected 1");
        end
        @(posedge clk1); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int nb, input bit gap);
        logic [31:0] w;
        for (int k = 0; k < nb; k++) begin
            w = frame[k / 4];
            send_byte(w[31 - 8 * (k % 4) -: 8], gap);
        end
    endtask

    task automatic do_load();
        @(posedge clk1); #1 load_req = 1'b1;
        @(posedge clk1); #1 load_req = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || error) && t < 60) begin
            @(posedge clk1); #1;
            t++;
        end
        check("outcome reached", done | error, 1);
        repeat (3) @(posedge clk1);
        #1;
    endtask

    task automatic end_check(input string tag);
        check({tag, " done"}, done, exp_run);
        check({tag, " error"}, error, !exp_run);
        check({tag, " cpu_hold"}, cpu_hold, !exp_run);
        check({tag, " cpu_start count"}, starts, exp_run);
        check({tag, " write count"}, writes, exp_writes);
        check({tag, " pending writes"}, exp_addr.size(), 0);
        check({tag, " in_ready"}, in_ready, 0);
    endtask

    task automatic reset_check(input string tag);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " cpu_hold"}, cpu_hold, 1);
        check({tag, " cpu_start"}, cpu_start, 0);
        check({tag, " done"}, done, 0);
        check({tag, " error"}, error, 0);
    endtask

    task automatic load_test1(input string tag);
        pay = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        plan(8, 0, 0);
        do_load();
        send_frame(nbytes, 1'b0);
        wait_end();
        end_check(tag);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 reset_check("reset");
        pay = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        check("model sum", model_sum(), 32'hb5b048a6);
        check("model bound B=1023 N=2", hdr_valid(2, 1023), 0);
        check("model bound B=1022 N=2", hdr_valid(2, 1022), 1);
        check("model bound N=1025", hdr_valid(1025, 0), 0);
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;

        // bytes offered while idle are dropped
        in_valid = 1'b1;
        in_data  = 8'h5a;
        repeat (4) @(posedge clk1);
        #1;
        check("idle in_ready", in_ready, 0);
        check("idle cpu_hold", cpu_hold, 1);
        in_valid = 1'b0;

        load_test1("basic");
        check("basic first data", first_data, 32'h28010078);
        check("basic last addr", last_addr, 7);
        check("basic last data", last_data, 32'hfc000000);

        pay = '{32'd85, 32'd0};
        plan(2, 120, 0);
        do_load();
        check("reload done cleared", done, 0);
        check("reload cpu_hold", cpu_hold, 1);
        send_frame(nbytes, 1'b1);
        wait_end();
        end_check("offset");
        check("offset last addr", last_addr, 121);
        check("offset addr held", mem_addr, 121);
        check("offset data held", mem_wdata, 0);

        pay = '{32'h11111111, 32'h22222222};
        plan(2, 1023, 0);
        do_load();
        send_frame(nbytes, 1'b0);
        wait_end();
        end_check("bound addr");
        in_valid = 1'b1;
        repeat (3) @(posedge clk1);
        #1;
        check("err in_ready", in_ready, 0);
        in_valid = 1'b0;

        pay.delete();
        plan(1025, 0, 0);
        do_load();
        check("err cleared by load_req", error, 0);
        send_frame(nbytes, 1'b0);
        wait_end();
        end_check("bound count");

        pay.delete();
        plan(0, 0, 0);
        do_load();
        send_frame(nbytes, 1'b0);
        wait_end();
        end_check("empty");

        // restart mid-word: the partial word must be discarded
        pay = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        plan(8, 0, 0);
        do_load();
        send_frame(6, 1'b0);
        load_test1("restart");

        plan(8, 0, 0);
        do_load();
        send_frame(20, 1'b0);
        repeat (2) @(posedge clk1);
        check("pre-reset writes", writes, 3);
        #3 rst_n = 1'b0;
        #1 reset_check("async reset");
        exp_addr.delete();
        exp_data.delete();
        @(posedge clk1);
        #1 rst_n = 1'b1;
        load_test1("after reset");

`ifdef LOADER_CHECKSUM_EN
        plan(8, 0, 1);
        do_load();
        send_frame(nbytes, 1'b0);
        wait_end();
        end_check("bad checksum");
        pay.delete();
        plan(0, 0, 0);
        do_load();
        check("chk error cleared", error, 0);
        send_frame(nbytes, 1'b0);
        wait_end();
        end_check("empty after chk");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
